// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operation encodings and default widths.
package logic_pipe_pkg;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/logic_pipe_slice.sv
// Single valid/ready register slice: accepts when empty or when its content is leaving this cycle.
module logic_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_q;
  logic [W-1:0] data_q;

  assign in_ready  = ~vld_q | out_ready;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (in_ready) vld_q <= in_valid;
      if (in_valid && in_ready) data_q <= in_data;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage pipelined bitwise NOR/OR/AND/XOR with valid/ready and a consumed-result counter.
// Defining LOGIC_PIPE_PARITY_EN adds result_par, the registered XOR-reduction of result.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic             result_par
`endif
);

  localparam int S1_W = 2 * WIDTH + 2;
`ifdef LOGIC_PIPE_PARITY_EN
  localparam int S2_W = WIDTH + 1;
`else
  localparam int S2_W = WIDTH;
`endif

  // Per-bit operation rebuilt from the inverted-A term captured in stage 1.
  function automatic logic op_bit(input logic tmp, input logic b_bit, input logic [1:0] sel);
    reg bit_p2;
    case (sel)
      OP_NOR:  bit_p2 = ~(~tmp | b_bit);
      OP_OR:   bit_p2 = ~tmp | b_bit;
      OP_AND:  bit_p2 = ~tmp & b_bit;
      default: bit_p2 = ~tmp ^ b_bit;
    endcase
    return bit_p2;
  endfunction

  logic [WIDTH-1:0] tmp_p0;
  logic [S1_W-1:0]  din_p0;
  logic             rdy_p1, vld_p1;
  logic [S1_W-1:0]  data_p1;
  logic [WIDTH-1:0] tmp_p1, b_p1, res_p1;
  logic [1:0]       op_p1;
  logic [S2_W-1:0]  din_p1;
  logic             rdy_p2, vld_p2;
  logic [S2_W-1:0]  data_p2;

  // Stage 0 -> 1: capture ~a, b and op
  assign tmp_p0   = ~a;
  assign din_p0   = {tmp_p0, b, op};
  // Reset forces in_ready low so the producer never sees a false acceptance.
  assign in_ready = rdy_p1 & ~rst;

  logic_pipe_slice #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy_p1),
    .in_data   (din_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p2),
    .out_data  (data_p1)
  );

  // Stage 1 -> 2: apply the operation and register the result
  assign {tmp_p1, b_p1, op_p1} = data_p1;

  always_comb begin
    res_p1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_p1[i] = op_bit(tmp_p1[i], b_p1[i], op_p1);
    end
  end

`ifdef LOGIC_PIPE_PARITY_EN
  assign din_p1 = {^res_p1, res_p1};
`else
  assign din_p1 = res_p1;
`endif

  logic_pipe_slice #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p2),
    .in_data   (din_p1),
    .out_valid (vld_p2),
    .out_ready (out_ready),
    .out_data  (data_p2)
  );

  // Stage 2 -> output
  assign out_valid = vld_p2;
  assign result    = data_p2[WIDTH-1:0];
`ifdef LOGIC_PIPE_PARITY_EN
  assign result_par = data_p2[WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule
